// File: rtl/ce_gen_pkg.sv
// ---------------------------------------------------------------------------
// ce_gen_pkg
// Shared types and constants for the fractional clock-enable generator.
//   ce_state_e      : lock/switch sequencer states (SETTLE, RUN, PEND)
//   MODE_PAL/NTSC   : encoding of the two increment sets
//   *_DEFAULT       : default parameter values for ce_nco_gen / ce_nco_chan
//   sel_width()     : width of a channel select, never less than one bit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package ce_gen_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        RUN    = 2'd1,
        PEND   = 2'd2
    } ce_state_e;

    localparam logic MODE_PAL  = 1'b0;
    localparam logic MODE_NTSC = 1'b1;

    localparam int ACC_W_DEFAULT       = 32;
    localparam int CHANNELS_DEFAULT    = 2;
    localparam int LOCK_CYCLES_DEFAULT = 16;

    // A one-channel build still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ce_nco_chan.sv
// ---------------------------------------------------------------------------
// ce_nco_chan
// One phase accumulator producing a single-cycle enable on every wrap.
//   refclk, rst_n      : core clock, asynchronous active-low reset
//   mode               : selects inc_pal (0) or inc_ntsc (1) for the add
//   inc_pal, inc_ntsc  : the two increments for this channel
//   clear              : synchronous clear of accumulator and enable
//   carry              : combinational carry of the add happening this cycle
//   ce                 : registered carry, i.e. the enable pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ce_nco_chan
    import ce_gen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [ACC_W-1:0] inc_pal,
    input  logic [ACC_W-1:0] inc_ntsc,
    input  logic             clear,
    output logic             carry,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W-1:0] sum;

    // The add is one bit wider than the accumulator; the extra bit is the
    // wrap that becomes the enable. It is exported unregistered so the top
    // level can align a mode switch to the exact cycle channel 0 wraps.
    always_comb begin
        inc_sel      = (mode == MODE_PAL) ? inc_pal : inc_ntsc;
        {carry, sum} = {1'b0, acc_q} + {1'b0, inc_sel};
    end

    // Accumulator and enable register. A clear wins over the add so that all
    // channels restart from phase zero together with no stray pulse.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce    <= 1'b0;
        end else if (clear) begin
            acc_q <= '0;
            ce    <= 1'b0;
        end else begin
            acc_q <= sum;
            ce    <= carry;
        end
    end

endmodule

// File: rtl/ce_nco_gen.sv
// ---------------------------------------------------------------------------
// ce_nco_gen
// Multi-channel fractional clock-enable generator with PAL/NTSC increment
// sets, phase-aligned run-time mode switching and a settle/lock indicator.
//   refclk, rst_n   : core clock, asynchronous active-low reset
//   mode_sel        : requested increment set (0 = PAL, 1 = NTSC)
//   cfg_we          : one-cycle increment write strobe
//   cfg_ch          : channel to write (out-of-range writes are dropped)
//   cfg_mode        : increment set to write
//   cfg_data        : increment value
//   ce              : registered per-channel enable pulses
//   mode_active     : increment set currently driving the accumulators
//   locked          : enables are running steadily at the active set's rate
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ce_nco_gen
    import ce_gen_pkg::*;
#(
    parameter int CHANNELS    = CHANNELS_DEFAULT,
    parameter int ACC_W       = ACC_W_DEFAULT,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic                           refclk,
    input  logic                           rst_n,
    input  logic                           mode_sel,
    input  logic                           cfg_we,
    input  logic [sel_width(CHANNELS)-1:0] cfg_ch,
    input  logic                           cfg_mode,
    input  logic [ACC_W-1:0]               cfg_data,
    output logic [CHANNELS-1:0]            ce,
    output logic                           mode_active,
    output logic                           locked
);

    localparam int CH_W  = sel_width(CHANNELS);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0]    inc_q [2][CHANNELS];
    logic [CHANNELS-1:0] carry_now;
    logic                unused_carries;

    ce_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                locked_q;

    logic                cfg_valid;
    logic                cfg_active;
    logic                lead_inc_zero;
    logic                switch_now;

    assign cfg_valid     = cfg_we && (int'(cfg_ch) < CHANNELS);
    assign cfg_active    = cfg_valid && (cfg_mode == mode_q);
    assign lead_inc_zero = (inc_q[mode_q][0] == '0);

    // Only channel 0's carry steers the switch; the rest are folded into a
    // deliberately unused net so the per-channel port stays uniform.
    assign unused_carries = ^carry_now;

    // Increment register file, both sets. A write lands in the addressed set
    // regardless of what the sequencer decides on the same edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    inc_q[m][c] <= '0;
                end
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (cfg_valid && (cfg_mode == 1'(m)) && (cfg_ch == CH_W'(c))) begin
                        inc_q[m][c] <= cfg_data;
                    end
                end
            end
        end
    end

    // Sequencer next-state logic. SETTLE counts down to lock, RUN watches for
    // a mode request, PEND waits for channel 0 to wrap so the new set starts
    // in phase with it. A zero channel-0 increment never wraps, so that case
    // switches at once. Any write to the active set restarts the settle
    // period but leaves the accumulators running.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        switch_now = 1'b0;

        case (state_q)
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (mode_sel != mode_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (mode_sel == mode_q) begin
                    state_d = RUN;
                end else if (carry_now[0] || lead_inc_zero) begin
                    switch_now = 1'b1;
                    mode_d     = mode_sel;
                    cnt_d      = CNT_W'(LOCK_CYCLES);
                    state_d    = SETTLE;
                end
            end
            default: begin
                cnt_d   = CNT_W'(LOCK_CYCLES);
                state_d = SETTLE;
            end
        endcase

        if (cfg_active) begin
            cnt_d   = CNT_W'(LOCK_CYCLES);
            state_d = SETTLE;
        end
    end

    // Sequencer registers. locked is registered from the next state so it
    // has no combinational path from any input.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            cnt_q    <= CNT_W'(LOCK_CYCLES);
            mode_q   <= MODE_PAL;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            locked_q <= (state_d != SETTLE);
        end
    end

    assign mode_active = mode_q;
    assign locked      = locked_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ce_nco_chan #(
            .ACC_W (ACC_W)
        ) u_chan (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .mode     (mode_q),
            .inc_pal  (inc_q[0][i]),
            .inc_ntsc (inc_q[1][i]),
            .clear    (switch_now),
            .carry    (carry_now[i]),
            .ce       (ce[i])
        );
    end

endmodule

// File: tb/tb_ce_nco_gen.sv
// ---------------------------------------------------------------------------
// tb_ce_nco_gen
// Self-checking bench for ce_nco_gen (2 channels, 32-bit, 16 settle cycles).
// The reference model tracks each channel as an unbounded phase count and
// the lock as "cycles since the last settle restart".
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ce_nco_gen;
    import ce_gen_pkg::*;

    localparam int CHANNELS    = 2;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;

    logic                refclk = 1'b0;
    logic                rst_n;
    logic                mode_sel;
    logic                cfg_we;
    logic [0:0]          cfg_ch;
    logic                cfg_mode;
    logic [ACC_W-1:0]    cfg_data;
    logic [CHANNELS-1:0] ce;
    logic                mode_active;
    logic                locked;

    ce_nco_gen #(
        .CHANNELS    (CHANNELS),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .mode_sel    (mode_sel),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_data    (cfg_data),
        .ce          (ce),
        .mode_active (mode_active),
        .locked      (locked)
    );

    always #5 refclk = ~refclk;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int step_no     = 0;
    int last_ce0_step = 0;
    int ce_pulse_count = 0;
    logic msel_cur = 1'b0;

    // Reference model state.
    longint unsigned     m_phase [CHANNELS];
    logic [ACC_W-1:0]    m_inc [2][CHANNELS];
    logic [CHANNELS-1:0] m_ce;
    logic                m_mode;
    logic                m_locked;
    logic                m_pend;
    int                  m_since;

    // Everything returns to power-up values, increments included.
    function automatic void modelReset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_phase[c]  = 0;
            m_inc[0][c] = '0;
            m_inc[1][c] = '0;
        end
        m_ce     = '0;
        m_mode   = MODE_PAL;
        m_locked = 1'b0;
        m_pend   = 1'b0;
        m_since  = 0;
    endfunction

    // One rising edge. A channel fires when its phase crosses a multiple of
    // 2^ACC_W. A pending switch fires when channel 0 crosses (or can never
    // cross) and restarts every phase from zero.
    function automatic void modelEdge(input logic msel, input logic we, input logic ch,
                                      input logic cmode, input logic [ACC_W-1:0] data);
        longint unsigned nxt;
        bit go;
        nxt = m_phase[0] + 64'(m_inc[m_mode][0]);
        go  = m_pend && (msel != m_mode) &&
              (((nxt >> ACC_W) != (m_phase[0] >> ACC_W)) || (m_inc[m_mode][0] == '0));
        if (go) begin
            m_mode = msel;
            for (int c = 0; c < CHANNELS; c++) m_phase[c] = 0;
            m_ce     = '0;
            m_since  = 0;
            m_locked = 1'b0;
            m_pend   = 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                nxt        = m_phase[c] + 64'(m_inc[m_mode][c]);
                m_ce[c]    = ((nxt >> ACC_W) != (m_phase[c] >> ACC_W));
                m_phase[c] = nxt;
            end
            if (we && (cmode == m_mode)) begin
                m_since  = 0;
                m_locked = 1'b0;
                m_pend   = 1'b0;
            end else if (!m_locked) begin
                m_since++;
                if (m_since >= LOCK_CYCLES) m_locked = 1'b1;
            end else begin
                m_pend = (msel != m_mode);
            end
        end
        if (we) m_inc[cmode][ch] = data;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h (step %0d)",
                   tag, observed, expected, step_no);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare.
    task automatic applyStimulus(input logic msel, input logic we, input logic ch,
                                 input logic cmode, input logic [ACC_W-1:0] data);
        mode_sel = msel;
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_mode = cmode;
        cfg_data = data;
        @(posedge refclk);
        modelEdge(msel, we, ch, cmode, data);
        step_no++;
        #1;
        checkOutput("ce", 64'(ce), 64'(m_ce));
        checkOutput("locked", 64'(locked), 64'(m_locked));
        checkOutput("mode_active", 64'(mode_active), 64'(m_mode));
        if (ce[0] === 1'b1) last_ce0_step = step_no;
        ce_pulse_count += int'(ce[0] === 1'b1) + int'(ce[1] === 1'b1);
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(msel_cur, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Steps until locked is seen high; gives up after 64.
    task automatic measureRelock(output int n_low);
        n_low = 0;
        while (locked !== 1'b1 && n_low < 64) begin
            n_low++;
            idle(1);
        end
    endtask

    // Steps until the requested mode is active and locked; false on timeout.
    task automatic waitModeLocked(input logic want, input int limit, output bit ok);
        int n;
        n = 0;
        while (!(mode_active === want && locked === 1'b1) && n < limit) begin
            idle(1);
            n++;
        end
        ok = (n < limit);
    endtask

    initial begin
        #400us;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0]      ce0_hist;
        logic [11:0]      ce1_hist;
        logic [ACC_W-1:0] d;
        logic             we;
        int               n;
        int               n_low;
        int               drops;
        int               gap_bad;
        int               pulses;
        int               prev_pulse;
        bit               ok;

        rst_n    = 1'b0;
        mode_sel = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = 1'b0;
        cfg_mode = 1'b0;
        cfg_data = '0;
        modelReset();

        // Reset values.
        repeat (3) @(posedge refclk);
        #1;
        checkOutput("reset_ce", 64'(ce), 64'd0);
        checkOutput("reset_locked", 64'(locked), 64'd0);
        checkOutput("reset_mode", 64'(mode_active), 64'd0);
        @(negedge refclk);
        rst_n = 1'b1;

        // Basic rates: ch0 = 1/4, ch1 = 1/2, lock 16 cycles after the last write.
        ce0_hist = '0;
        ce1_hist = '0;
        applyStimulus(1'b0, 1'b1, 1'b0, MODE_PAL, 32'h4000_0000);
        ce0_hist[0] = ce[0]; ce1_hist[0] = ce[1];
        applyStimulus(1'b0, 1'b1, 1'b1, MODE_PAL, 32'h8000_0000);
        ce0_hist[1] = ce[0]; ce1_hist[1] = ce[1];
        for (int k = 2; k < 12; k++) begin
            idle(1);
            ce0_hist[k] = ce[0];
            ce1_hist[k] = ce[1];
        end
        checkOutput("ce0_pattern", 64'(ce0_hist), 64'h110);
        checkOutput("ce1_pattern", 64'(ce1_hist), 64'hAA8);
        idle(5);
        checkOutput("lock_before_16", 64'(locked), 64'd0);
        idle(1);
        checkOutput("lock_at_16", 64'(locked), 64'd1);

        // Loading the inactive set leaves the lock alone.
        applyStimulus(1'b0, 1'b1, 1'b0, MODE_NTSC, 32'h3000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, MODE_NTSC, 32'h1234_5678);
        checkOutput("inactive_write_lock", 64'(locked), 64'd1);

        // Active-set reconfiguration: lock drops for 16 cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, MODE_PAL, 32'h2000_0000);
        checkOutput("reconfig_drop", 64'(locked), 64'd0);
        measureRelock(n_low);
        checkOutput("reconfig_low_cycles", 64'(n_low), 64'd16);

        // Mode switch lands exactly where ch0 would have pulsed.
        msel_cur = 1'b1;
        n = 0;
        while (mode_active !== 1'b1 && n < 40) begin
            idle(1);
            n++;
        end
        checkOutput("switch_seen", 64'(n < 40), 64'd1);
        checkOutput("switch_ce", 64'(ce), 64'd0);
        checkOutput("switch_locked", 64'(locked), 64'd0);
        checkOutput("switch_phase", 64'(step_no - last_ce0_step), 64'd8);
        measureRelock(n_low);
        checkOutput("switch_low_cycles", 64'(n_low), 64'd16);

        // Abort: a one-cycle request for the other set never switches.
        drops = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        if (locked !== 1'b1) drops++;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (locked !== 1'b1) drops++;
        end
        checkOutput("abort_drops", 64'(drops), 64'd0);
        checkOutput("abort_mode", 64'(mode_active), 64'd1);

        // Reconfigure active (NTSC) and inactive (PAL) sets.
        applyStimulus(1'b1, 1'b1, 1'b1, MODE_NTSC, $urandom | 32'h0100_0000);
        checkOutput("active_write_drop", 64'(locked), 64'd0);
        measureRelock(n_low);
        checkOutput("active_write_low", 64'(n_low), 64'd16);
        applyStimulus(1'b1, 1'b1, 1'b1, MODE_PAL, $urandom);
        checkOutput("pal_write_lock", 64'(locked), 64'd1);

        // Randomized mode requests and config writes against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) msel_cur = ~msel_cur;
            we = ($urandom_range(0, 9) == 0);
            d  = $urandom | 32'h0100_0000;
            if ($urandom_range(0, 7) == 0) d = '0;
            applyStimulus(msel_cur, we, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), d);
        end

        // Reset in the middle of a pending switch, with ce[1] high.
        applyStimulus(msel_cur, 1'b1, 1'b0, MODE_NTSC, 32'h0100_0000);
        applyStimulus(msel_cur, 1'b1, 1'b1, MODE_NTSC, 32'h8000_0000);
        applyStimulus(msel_cur, 1'b1, 1'b0, MODE_PAL, 32'h4000_0000);
        msel_cur = 1'b0;
        waitModeLocked(1'b0, 600, ok);
        checkOutput("to_pal_timeout", 64'(ok), 64'd1);
        msel_cur = 1'b1;
        waitModeLocked(1'b1, 600, ok);
        checkOutput("to_ntsc_timeout", 64'(ok), 64'd1);
        msel_cur = 1'b0;
        idle(3);
        checkOutput("pend_locked", 64'(locked), 64'd1);
        checkOutput("pend_mode", 64'(mode_active), 64'd1);
        n = 0;
        while (ce[1] !== 1'b1 && n < 4) begin
            idle(1);
            n++;
        end
        checkOutput("pend_ce1_seen", 64'(ce[1]), 64'd1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_ce", 64'(ce), 64'd0);
        checkOutput("async_locked", 64'(locked), 64'd0);
        checkOutput("async_mode", 64'(mode_active), 64'd0);
        modelReset();
        mode_sel = 1'b0;
        #1;
        rst_n = 1'b1;

        // After reset every increment is zero in both sets.
        ce_pulse_count = 0;
        measureRelock(n_low);
        checkOutput("post_reset_lock", 64'(n_low), 64'd16);
        idle(20);
        msel_cur = 1'b1;
        waitModeLocked(1'b1, 40, ok);
        checkOutput("zero_switch_ntsc", 64'(ok), 64'd1);
        idle(10);
        msel_cur = 1'b0;
        waitModeLocked(1'b0, 40, ok);
        checkOutput("zero_switch_pal", 64'(ok), 64'd1);
        checkOutput("zero_inc_pulses", 64'(ce_pulse_count), 64'd0);

        // Fractional rate 1/3 over 3000 cycles from phase zero.
        applyStimulus(1'b0, 1'b1, 1'b0, MODE_PAL, 32'h5555_5555);
        pulses     = 0;
        gap_bad    = 0;
        prev_pulse = -1;
        for (int k = 0; k < 3000; k++) begin
            idle(1);
            if (ce[0] === 1'b1) begin
                pulses++;
                if (prev_pulse >= 0 && (k - prev_pulse) != 3) gap_bad++;
                prev_pulse = k;
            end
        end
        checkOutput("frac_count_range", 64'(pulses >= 999 && pulses <= 1001), 64'd1);
        checkOutput("frac_spacing", 64'(gap_bad), 64'd0);

        if (fail_count != 0) $display("[TB] %0d comparisons did not hold", fail_count);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ce_nco_gen.md
# ce_nco_gen

Multi-channel fractional clock-enable generator for the core clock domain. One accumulator per channel (NCO) produces single-cycle enable pulses at any rational fraction of `refclk`. Each channel holds two increment sets: mode 0 (PAL) and mode 1 (NTSC). A run-time mode switch is phase-aligned to channel 0, clears all accumulators, and drops `locked` until the outputs have settled. It replaces a dedicated second PLL output for the PAL/NTSC machine rates; video and CPU logic gate on `ce[]` instead.

## Interface
Parameters:
- `CHANNELS`, 2: number of enable outputs, 1..8.
- `ACC_W`, 32: accumulator and increment width, 8..32.
- `LOCK_CYCLES`, 16: settle cycles after reset, mode switch or active-set reconfiguration, ≥1.

Ports (single clock; reset is asynchronous and active-low):
- `refclk`  in  1  core clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mode_sel`  in  1  requested increment set (0 = PAL, 1 = NTSC).
- `cfg_we`  in  1  increment write strobe, one cycle.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  channel to write.
- `cfg_mode`  in  1  set to write.
- `cfg_data`  in  ACC_W  increment value.
- `ce`  out  CHANNELS  per-channel enable pulses, registered.
- `mode_active`  out  1  set currently driving the accumulators.
- `locked`  out  1  high when enables are stable at the active set's rate.

## Operation
- Per channel i: {carry, sum} = acc[i] + inc[mode_active][i] (ACC_W+1 bits). acc[i] ← sum; ce[i] ← carry. f_ce = f_refclk · inc / 2^ACC_W.
  - inc = 0: the channel never fires.
  - inc = 2^ACC_W − 1 fires on all cycles except one per 2^ACC_W.
- Reset values: acc = 0, all inc = 0, ce = 0, mode_active = 0, locked = 0, state = SETTLE, settle counter = LOCK_CYCLES.
- States:
  - SETTLE: accumulators run. The counter decrements each cycle. When it reaches 0: locked ← 1, go to RUN.
  - RUN: locked = 1. If mode_sel ≠ mode_active, go to PEND.
  - PEND: locked stays 1 and accumulators keep running on the old set. On the cycle the channel 0 add carries, or immediately if the old set's inc[0] = 0:
    - mode_active ← mode_sel; all acc ← 0; ce ← 0 that cycle;
    - counter ← LOCK_CYCLES; locked ← 0; go to SETTLE.
  - If mode_sel returns to mode_active while in PEND: back to RUN, no switch.
- Config writes:
  - Any cfg_we writes inc[cfg_mode][cfg_ch] at the edge; the new value is used from the next add.
  - If cfg_mode = mode_active: locked ← 0, counter reloaded, state SETTLE. Accumulators are not cleared.
  - If cfg_mode ≠ mode_active: no effect on locked or state.
- Simultaneous events:
  - cfg_we to the active set on the switch cycle: the switch wins, and the write lands in its addressed set.
  - mode_sel toggling during SETTLE: recorded only after RUN is reached.
- cfg_ch ≥ CHANNELS: write ignored.

## Timing
- ce latency: one cycle after the carrying add. Cycle 1 is the first rising edge after rst_n deasserts.
  - Example, ACC_W=32, inc = 0x4000_0000: ce high in cycles 4, 8, 12, …
- Reset: rst_n low forces all outputs to their reset values asynchronously, including mid-pulse and mid-switch.
- locked rises exactly LOCK_CYCLES cycles after the last event that reloaded the counter.
- Switch cost: at most one old-mode channel 0 period plus LOCK_CYCLES.
- No combinational path from any input to any output.

## Structure
- Package `ce_gen_pkg`:
  - state enum {SETTLE, RUN, PEND};
  - `MODE_PAL` = 0, `MODE_NTSC` = 1;
  - default ACC_W.
- Sub-module `ce_nco_chan`: one accumulator, increment mux by mode, registered carry, synchronous clear input. Instantiated CHANNELS times by a generate loop.
- Top level: increment register file, settle counter, FSM.

## Test plan
- Reset, inc0[PAL] = 0x4000_0000, inc1[PAL] = 0x8000_0000 → ce[0] at cycles 4, 8, …; ce[1] every 2nd cycle; locked rises 16 cycles after the last write.
- Fractional rate: inc = 0x5555_5555 over 3000 cycles → exactly 1000 ce pulses (±1), spacing only 3.
- Mode switch: RUN on PAL with inc0 = 0x2000_0000, NTSC set loaded, mode_sel → 1 → switch on the cycle ce[0] would pulse, ce all 0 that cycle, mode_active = 1 next cycle, locked low for 16 cycles.
- Abort: mode_sel 0→1→0 within one ch0 period → no switch, locked never drops.
- Reconfig: write to active set in RUN → locked low 16 cycles, acc not cleared; write to inactive set → locked stays high.
- rst_n pulsed low mid-PEND → ce = 0, locked = 0, mode_active = 0 immediately; all inc read back as non-firing (zero).
